data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 101 ++++++++++
 tb/tb_data_mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Pipeline <-> data memory request/response bundle.
// DMEM_MISALIGN_CHECK_EN adds the misaligned flag to the bundle.
interface dmem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        resp_valid;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        misaligned;

  modport master (output mem_read, mem_write, address, write_data,
                  input  read_data, stall, resp_valid, misaligned);
  modport slave  (input  mem_read, mem_write, address, write_data,
                  output read_data, stall, resp_valid, misaligned);
`else
  modport master (output mem_read, mem_write, address, write_data,
                  input  read_data, stall, resp_valid);
  modport slave  (input  mem_read, mem_write, address, write_data,
                  output read_data, stall, resp_valid);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory: IDLE -> BUSY -> DONE, stalls the pipeline LATENCY cycles per access.
// Optional alignment checking under DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 1024
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        rv_q;
  logic [31:0] mem [DEPTH];

  logic          req, acc_wr, oor, mis_c, enter_done, commit;
  logic [31:0]   acc_addr, acc_wdata, rd_val;
  logic [AW-1:0] idx;

  assign req = bus.mem_read | bus.mem_write;

  // With LATENCY=1 the access completes in the accept cycle, so use live inputs there.
  assign acc_wr    = (state_q == IDLE) ? bus.mem_write  : wr_q;
  assign acc_addr  = (state_q == IDLE) ? bus.address    : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.write_data : wdata_q;

  assign oor = |acc_addr[31:12];
  assign idx = acc_addr[2 +: AW];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic mis_q;
  assign mis_c          = |acc_addr[1:0];
  assign bus.misaligned = mis_q;
`else
  logic unused_lsb;
  assign unused_lsb = ^acc_addr[1:0];
  assign mis_c      = 1'b0;
`endif

  assign enter_done = !rst && ((state_q == IDLE && req && LATENCY == 1) ||
                               (state_q == BUSY && cnt_q == 4'd1));
  assign commit     = enter_done && acc_wr && !oor && !mis_c;
  assign rd_val     = (acc_wr || oor || mis_c) ? 32'h0 : mem[idx];

  assign bus.stall      = !rst && ((state_q == IDLE && req) || state_q == BUSY);
  assign bus.resp_valid = rv_q;
  assign bus.read_data  = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      rv_q    <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      rv_q  <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (req) begin
          wr_q    <= bus.mem_write;
          addr_q  <= bus.address;
          wdata_q <= bus.write_data;
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= (LATENCY == 1) ? DONE : BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (enter_done) begin
        rv_q    <= 1'b1;
        rdata_q <= rd_val;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis_q   <= mis_c;
`endif
      end
    end
  end

  // Array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= acc_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder (LATENCY=3), plus reset-abort,
// back-to-back and misalignment sequences.
module tb_data_mem_responder;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if bus();

  data_mem_responder #(.LATENCY(LAT), .DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called between a negedge and the following posedge; returns at the same phase.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input bit hold);
    logic [1:0] lsb;
    lsb = addr[1:0];
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    for (int i = 0; i < LAT; i++) begin
      #1;
      chk($sformatf("stall[%0d] @%h", i, addr), 32'(bus.stall), 32'd1);
      chk($sformatf("rv_in_stall[%0d] @%h", i, addr), 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    chk($sformatf("done_stall @%h", addr), 32'(bus.stall), 32'd0);
    chk($sformatf("done_rv @%h", addr), 32'(bus.resp_valid), 32'd1);
    chk($sformatf("done_rdata @%h", addr), bus.read_data, exp);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk($sformatf("done_mis @%h", addr), 32'(bus.misaligned), 32'(lsb != 2'b00));
`endif
    if (!hold) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    @(negedge clk);
    #1;
    chk($sformatf("idle_rv @%h", addr), 32'(bus.resp_valid), 32'd0);
    if (!hold) begin
      chk($sformatf("idle_stall @%h", addr), 32'(bus.stall), 32'd0);
      chk($sformatf("idle_rdata_hold @%h", addr), bus.read_data, exp);
`ifdef DMEM_MISALIGN_CHECK_EN
      chk($sformatf("idle_mis @%h", addr), 32'(bus.misaligned), 32'd0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0024, 32'hA5A5A5A5, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,        32'hA5A5A5A5};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_1010, 32'h11111111, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hCAFEF00D, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        32'hCAFEF00D};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0BADF00D, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'h0BADF00D};

    // Reset with a request present: stall must stay low.
    rst            = 1'b1;
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b0;
    bus.address    = 32'h10;
    bus.write_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_rv", 32'(bus.resp_valid), 32'd0);
    chk("reset_rdata", bus.read_data, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("reset_mis", 32'(bus.misaligned), 32'd0);
`endif
    rst          = 1'b0;
    bus.mem_read = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, 1'b0);

    // Reset during the second stall cycle aborts the write to 0x20.
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;
    bus.address    = 32'h20;
    bus.write_data = 32'h12345678;
    #1;
    chk("abort_stall1", 32'(bus.stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_stall_in_rst", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    chk("abort_rv0", 32'(bus.resp_valid), 32'd0);
    chk("abort_rdata_cleared", bus.read_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort_no_rv[%0d]", i), 32'(bus.resp_valid), 32'd0);
      chk($sformatf("abort_no_stall[%0d]", i), 32'(bus.stall), 32'd0);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

    // Back-to-back reads: request held through DONE, next one presented in IDLE.
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    access(1'b1, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0);

    // Misaligned write to 0x13.
    access(1'b0, 1'b1, 32'h13, 32'h55AA55AA, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
`else
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'h55AA55AA, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
